// File: rtl/pong_pkg.sv
// Shared pong definitions: FSM encoding, coordinate/score types and the
// screen and paddle geometry used by the ball, paddle and video blocks.
package pong_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SERVE  = 3'd1,
    ST_MOVE   = 3'd2,
    ST_SCORED = 3'd3,
    ST_OVER   = 3'd4
  } ball_state_e;

  localparam int unsigned COORD_W = 32'd10;
  localparam int unsigned SCORE_W = 32'd4;

  typedef logic [COORD_W-1:0] coord_t;
  typedef logic [COORD_W:0]   coord_ext_t;
  typedef logic [SCORE_W-1:0] score_t;

  localparam int unsigned SCR_H_ACT  = 32'd640;
  localparam int unsigned SCR_V_ACT  = 32'd480;
  localparam int unsigned BALL_HALF  = 32'd4;
  localparam int unsigned BALL_STEP  = 32'd2;
  localparam int unsigned PAD_L_X    = 32'd20;
  localparam int unsigned PAD_R_X    = 32'd620;
  localparam int unsigned PAD_HALF_W = 32'd5;
  localparam int unsigned PAD_HALF_H = 32'd50;

  // Coordinates are compared one bit wider so sums never wrap.
  function automatic coord_ext_t ext_coord(input coord_t v);
    return {1'b0, v};
  endfunction

endpackage

// File: rtl/ball_ctrl_if.sv
// Ball controller signal bundle: frame tick, serve request and paddle
// positions in; ball position, scores, event pulses and FSM state out.
interface ball_ctrl_if;
  import pong_pkg::*;

  logic       i_tick;
  logic       i_start;
  coord_t     i_pl_y;
  coord_t     i_pr_y;
  coord_t     o_ball_x;
  coord_t     o_ball_y;
  score_t     o_score_l;
  score_t     o_score_r;
  logic       o_hit;
  logic       o_point;
  logic [2:0] o_state;

  modport master (
    output i_tick, i_start, i_pl_y, i_pr_y,
    input  o_ball_x, o_ball_y, o_score_l, o_score_r, o_hit, o_point, o_state
  );

  modport slave (
    input  i_tick, i_start, i_pl_y, i_pr_y,
    output o_ball_x, o_ball_y, o_score_l, o_score_r, o_hit, o_point, o_state
  );

endinterface

// File: rtl/ball_paddle_hit.sv
// Combinational paddle contact window for one paddle; the caller gates it
// with the ball's horizontal direction.
module ball_paddle_hit
  import pong_pkg::*;
#(
  parameter int unsigned PAD_X   = PAD_L_X,
  parameter int unsigned PAD_HW  = PAD_HALF_W,
  parameter int unsigned PAD_HH  = PAD_HALF_H,
  parameter int unsigned BALL_R  = BALL_HALF,
  parameter int unsigned STEP    = BALL_STEP,
  parameter bit          IS_LEFT = 1'b1
) (
  input  coord_t i_bx,
  input  coord_t i_by,
  input  coord_t i_py,
  output logic   o_hit
);

  localparam coord_ext_t C_PAD_X = coord_ext_t'(PAD_X);
  localparam coord_ext_t C_STEP  = coord_ext_t'(STEP);
  localparam coord_ext_t C_VWIN  = coord_ext_t'(PAD_HH + BALL_R);

  coord_ext_t w_bx;
  coord_ext_t w_by;
  coord_ext_t w_py;
  logic       w_reach;
  logic       w_vert;

  assign w_bx = ext_coord(i_bx);
  assign w_by = ext_coord(i_by);
  assign w_py = ext_coord(i_py);

  // |by - py| < window, rearranged so neither side subtracts.
  assign w_vert = ((w_by + C_VWIN) > w_py) && ((w_py + C_VWIN) > w_by);

  if (IS_LEFT) begin : g_left
    localparam coord_ext_t C_FACE = coord_ext_t'(PAD_X + PAD_HW + BALL_R);
    assign w_reach = (w_bx <= (C_FACE + C_STEP)) && (w_bx > C_PAD_X);
  end else begin : g_right
    localparam coord_ext_t C_FACE = coord_ext_t'(PAD_X - PAD_HW - BALL_R);
    assign w_reach = ((w_bx + C_STEP) >= C_FACE) && (w_bx < C_PAD_X);
  end

  assign o_hit = w_reach && w_vert;

endmodule

// File: rtl/ball_ctrl.sv
// Pong ball controller: serve delay, ball motion with wall and paddle
// bounces, miss detection and scoring, advanced once per frame tick.
module ball_ctrl
  import pong_pkg::*;
#(
  parameter int unsigned H_ACT       = SCR_H_ACT,
  parameter int unsigned V_ACT       = SCR_V_ACT,
  parameter int unsigned BALL_R      = BALL_HALF,
  parameter int unsigned STEP        = BALL_STEP,
  parameter int unsigned PL_X        = PAD_L_X,
  parameter int unsigned PR_X        = PAD_R_X,
  parameter int unsigned PAD_HW      = PAD_HALF_W,
  parameter int unsigned PAD_HH      = PAD_HALF_H,
  parameter int unsigned SERVE_TICKS = 32'd60,
  parameter int unsigned WIN         = 32'd9
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  ball_ctrl_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(SERVE_TICKS + 32'd1);
  typedef logic [CNT_W-1:0] cnt_t;

  localparam coord_t     C_CX      = coord_t'(H_ACT / 32'd2);
  localparam coord_t     C_CY      = coord_t'(V_ACT / 32'd2);
  localparam coord_ext_t C_STEP    = coord_ext_t'(STEP);
  localparam coord_ext_t C_TOP_LIM = coord_ext_t'(BALL_R + STEP);
  localparam coord_ext_t C_TOP_POS = coord_ext_t'(BALL_R);
  localparam coord_ext_t C_BOT_POS = coord_ext_t'(V_ACT - 32'd1 - BALL_R);
  localparam coord_ext_t C_EDGE_L  = coord_ext_t'(BALL_R + STEP);
  localparam coord_ext_t C_EDGE_R  = coord_ext_t'(H_ACT - 32'd1 - BALL_R);
  localparam coord_ext_t C_FACE_L  = coord_ext_t'(PL_X + PAD_HW + BALL_R);
  localparam coord_ext_t C_FACE_R  = coord_ext_t'(PR_X - PAD_HW - BALL_R);
  localparam score_t     C_WIN     = score_t'(WIN);
  localparam cnt_t       C_SERVE   = cnt_t'(SERVE_TICKS);

  ball_state_e r_state, w_state_nxt;
  coord_t      r_bx, r_by, w_bx_nxt, w_by_nxt;
  logic        r_dx_left, r_dy_up, w_dx_left_nxt, w_dy_up_nxt;
  score_t      r_score_l, r_score_r, w_score_l_nxt, w_score_r_nxt;
  cnt_t        r_cnt, w_cnt_nxt, w_cnt_inc;
  logic        r_hit, r_point, w_hit_nxt, w_point_nxt;

  logic        w_pad_l, w_pad_r;
  coord_ext_t  w_bx, w_by, w_x_inc, w_y_inc;

  ball_paddle_hit #(
    .PAD_X(PL_X), .PAD_HW(PAD_HW), .PAD_HH(PAD_HH),
    .BALL_R(BALL_R), .STEP(STEP), .IS_LEFT(1'b1)
  ) u_hit_l (
    .i_bx(r_bx), .i_by(r_by), .i_py(bus.i_pl_y), .o_hit(w_pad_l)
  );

  ball_paddle_hit #(
    .PAD_X(PR_X), .PAD_HW(PAD_HW), .PAD_HH(PAD_HH),
    .BALL_R(BALL_R), .STEP(STEP), .IS_LEFT(1'b0)
  ) u_hit_r (
    .i_bx(r_bx), .i_by(r_by), .i_py(bus.i_pr_y), .o_hit(w_pad_r)
  );

  assign w_bx      = ext_coord(r_bx);
  assign w_by      = ext_coord(r_by);
  assign w_x_inc   = w_bx + C_STEP;
  assign w_y_inc   = w_by + C_STEP;
  assign w_cnt_inc = r_cnt + cnt_t'(1'b1);

  // Next-state and next-value logic; decrements are only taken when the
  // matching edge limit is not reached, so they cannot underflow.
  always_comb begin
    w_state_nxt   = r_state;
    w_bx_nxt      = r_bx;
    w_by_nxt      = r_by;
    w_dx_left_nxt = r_dx_left;
    w_dy_up_nxt   = r_dy_up;
    w_score_l_nxt = r_score_l;
    w_score_r_nxt = r_score_r;
    w_cnt_nxt     = r_cnt;
    w_hit_nxt     = 1'b0;
    w_point_nxt   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_bx_nxt = C_CX;
        w_by_nxt = C_CY;
        if (bus.i_start) begin
          w_state_nxt = ST_SERVE;
          w_cnt_nxt   = '0;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_SERVE: begin
        if (bus.i_tick) begin
          if (w_cnt_inc == C_SERVE) begin
            w_state_nxt = ST_MOVE;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = w_cnt_inc;
          end
        end else begin
          w_cnt_nxt = r_cnt;
        end
      end
      ST_MOVE: begin
        if (bus.i_tick) begin
          if (r_dy_up) begin
            if (w_by <= C_TOP_LIM) begin
              w_by_nxt    = C_TOP_POS[COORD_W-1:0];
              w_dy_up_nxt = 1'b0;
            end else begin
              w_by_nxt = r_by - C_STEP[COORD_W-1:0];
            end
          end else begin
            if (w_y_inc >= C_BOT_POS) begin
              w_by_nxt    = C_BOT_POS[COORD_W-1:0];
              w_dy_up_nxt = 1'b1;
            end else begin
              w_by_nxt = w_y_inc[COORD_W-1:0];
            end
          end
          if (r_dx_left && w_pad_l) begin
            w_bx_nxt      = C_FACE_L[COORD_W-1:0];
            w_dx_left_nxt = 1'b0;
            w_hit_nxt     = 1'b1;
          end else if (!r_dx_left && w_pad_r) begin
            w_bx_nxt      = C_FACE_R[COORD_W-1:0];
            w_dx_left_nxt = 1'b1;
            w_hit_nxt     = 1'b1;
          end else if (r_dx_left && (w_bx <= C_EDGE_L)) begin
            w_score_r_nxt = (r_score_r < C_WIN) ? (r_score_r + score_t'(1'b1)) : r_score_r;
            w_dx_left_nxt = 1'b1;
            w_point_nxt   = 1'b1;
            w_state_nxt   = ST_SCORED;
          end else if (!r_dx_left && (w_x_inc >= C_EDGE_R)) begin
            w_score_l_nxt = (r_score_l < C_WIN) ? (r_score_l + score_t'(1'b1)) : r_score_l;
            w_dx_left_nxt = 1'b0;
            w_point_nxt   = 1'b1;
            w_state_nxt   = ST_SCORED;
          end else if (r_dx_left) begin
            w_bx_nxt = r_bx - C_STEP[COORD_W-1:0];
          end else begin
            w_bx_nxt = w_x_inc[COORD_W-1:0];
          end
        end else begin
          w_state_nxt = ST_MOVE;
        end
      end
      ST_SCORED: begin
        w_bx_nxt  = C_CX;
        w_by_nxt  = C_CY;
        w_cnt_nxt = '0;
        if ((r_score_l == C_WIN) || (r_score_r == C_WIN)) begin
          w_state_nxt = ST_OVER;
        end else begin
          w_state_nxt = ST_SERVE;
        end
      end
      ST_OVER: begin
        w_bx_nxt = C_CX;
        w_by_nxt = C_CY;
        if (bus.i_start) begin
          w_score_l_nxt = '0;
          w_score_r_nxt = '0;
          w_cnt_nxt     = '0;
          w_state_nxt   = ST_SERVE;
        end else begin
          w_state_nxt = ST_OVER;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset parks the ball at centre in IDLE.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= ST_IDLE;
      r_bx      <= C_CX;
      r_by      <= C_CY;
      r_dx_left <= 1'b0;
      r_dy_up   <= 1'b0;
      r_score_l <= '0;
      r_score_r <= '0;
      r_cnt     <= '0;
      r_hit     <= 1'b0;
      r_point   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_bx      <= w_bx_nxt;
      r_by      <= w_by_nxt;
      r_dx_left <= w_dx_left_nxt;
      r_dy_up   <= w_dy_up_nxt;
      r_score_l <= w_score_l_nxt;
      r_score_r <= w_score_r_nxt;
      r_cnt     <= w_cnt_nxt;
      r_hit     <= w_hit_nxt;
      r_point   <= w_point_nxt;
    end
  end

  assign bus.o_ball_x  = r_bx;
  assign bus.o_ball_y  = r_by;
  assign bus.o_score_l = r_score_l;
  assign bus.o_score_r = r_score_r;
  assign bus.o_hit     = r_hit;
  assign bus.o_point   = r_point;
  assign bus.o_state   = r_state;

endmodule

// File: doc/ball_ctrl.md
BALL_CTRL -- requirements
Module: ball_ctrl

Interface
REQ-001 Parameter H_ACT, default 640, active pixels per line.
REQ-002 Parameter V_ACT, default 480, active lines per frame.
REQ-003 Parameter BALL_R, default 4, ball half-size in pixels.
REQ-004 Parameter STEP, default 2, pixels moved per axis per frame tick.
REQ-005 Parameter PL_X / PR_X, default 20 / 620, left/right paddle centre x.
REQ-006 Parameter PAD_HW / PAD_HH, default 5 / 50, paddle half-width / half-height.
REQ-007 Parameter SERVE_TICKS, default 60, frame ticks of serve delay.
REQ-008 Parameter WIN, default 9, winning score.
REQ-009 Port clk  in  1  system clock; all state on rising edge.
REQ-010 Port rst  in  1  reset, asynchronous, active-low.
REQ-011 Port tick  in  1  one-cycle pulse per frame, at start of vertical blank.
REQ-012 Port start  in  1  level, debounced serve/restart request.
REQ-013 Port pl_y, pr_y  in  10 each  left/right paddle centre y.
REQ-014 Port ball_x, ball_y  out  10 each  ball centre.
REQ-015 Port score_l, score_r  out  4 each  scores, 0..WIN.
REQ-016 Port hit  out  1  one-cycle pulse on a paddle bounce.
REQ-017 Port point  out  1  one-cycle pulse when a point is scored.
REQ-018 Port state  out  3  current FSM state encoding.

Function
REQ-019 FSM states: IDLE, SERVE, MOVE, SCORED, OVER; position updates only in MOVE, only on a cycle with tick=1.
REQ-020 IDLE: ball at (H_ACT/2, V_ACT/2); start=1 -> SERVE with serve counter cleared.
REQ-021 SERVE: counter increments per tick; at SERVE_TICKS ticks -> MOVE; start ignored.
REQ-022 MOVE x: bx +/- STEP per dx; y: by +/- STEP per dy; both axes evaluated in the same tick, with their results applied together.
REQ-023 Top wall: dy up and by <= BALL_R+STEP -> by=BALL_R, dy=down; bottom: dy down and by >= V_ACT-1-BALL_R-STEP -> by=V_ACT-1-BALL_R, dy=up.
REQ-024 Left paddle hit: dx left, bx-STEP <= PL_X+PAD_HW+BALL_R, bx > PL_X, |by-pl_y| < PAD_HH+BALL_R -> bx=PL_X+PAD_HW+BALL_R, dx=right, hit=1.
REQ-025 Right paddle hit mirrors REQ-024 using PR_X, pr_y, PR_X-PAD_HW-BALL_R, bx < PR_X.
REQ-026 All comparisons are computed in 11-bit unsigned with terms moved to avoid subtraction underflow; no wrap-around of ball_x/ball_y is permitted.
REQ-027 Miss: dx left and bx <= BALL_R+STEP without a hit -> score_r+1, point=1, -> SCORED; right edge mirror increments score_l.
REQ-028 Paddle hit takes priority over miss in the same tick; wall and paddle bounce in the same tick both apply.
REQ-029 SCORED (one cycle): ball recentred; dx points toward the player who lost the point; dy unchanged; if the incremented score == WIN -> OVER, else -> SERVE.
REQ-030 OVER: ball held at centre; start=1 -> scores cleared, -> SERVE.
REQ-031 hit and point are registered and are high for exactly one clk cycle; both are never high in the same cycle.
REQ-032 Scores saturate at WIN; no increment occurs in OVER.

Reset
REQ-033 rst=0 asynchronously forces: state IDLE, ball_x=H_ACT/2, ball_y=V_ACT/2, dx=right, dy=down, scores 0, serve counter 0, hit=0, point=0.
REQ-034 Reset asserted mid-MOVE or mid-SERVE discards all progress; after release the block waits in IDLE for start.

Structure
REQ-035 Shared package pong_pkg holds the state enum and screen/paddle geometry constants also used by the paddle and video blocks.
REQ-036 One sub-module, ball_paddle_hit, is instantiated twice (left, right) and evaluates the REQ-024 window combinationally.

Verification
REQ-037 Reset, then start=1, then 60 ticks -> state MOVE; first further tick -> ball (322,242).
REQ-038 Ball at (100,5), dy up, then tick -> ball_y=4, dy=down, no hit.
REQ-039 Ball at (31,240), dx left, pl_y=240, then tick -> ball_x=29, dx=right, hit pulse of 1 cycle.
REQ-040 Ball at (5,240), dx left, pl_y=400, then tick -> score_r=1, point pulse, SCORED then SERVE, ball (320,240), dx=left.
REQ-041 score_l=8 and right miss -> score_l=9, state OVER; start -> scores 0, SERVE.
REQ-042 rst=0 pulsed mid-MOVE -> all outputs immediately at reset values, state IDLE.
